// File: rtl/issue_scoreboard_bypass.sv
// rtl/issue_scoreboard_bypass.sv - decode operand path with pending-write scoreboard, priority bypass and registered issue stage
module issue_scoreboard_bypass #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 3,
    parameter int CNT_W   = 2
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [4:0]              rs1_i,
    input  logic [4:0]              rs2_i,
    input  logic                    rs1_req_i,
    input  logic                    rs2_req_i,
    input  logic [4:0]              rd_i,
    input  logic                    wb_en_i,
    input  logic [XLEN-1:0]         reg_rdata1_i,
    input  logic [XLEN-1:0]         reg_rdata2_i,
    input  logic [NUM_FWD*5-1:0]    fwd_reg_i,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data_i,
    input  logic [NUM_FWD-1:0]      fwd_valid_i,
    input  logic                    retire_en_i,
    input  logic [4:0]              retire_reg_i,
    input  logic                    flush_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [XLEN-1:0]         rs1_data_o,
    output logic [XLEN-1:0]         rs2_data_o,
    output logic [4:0]              out_rd_o,
    output logic [30:0]             pending_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q    [32];
    logic [CNT_W-1:0] cnt_next [32];
    logic [30:0]      pend_next;

    logic [XLEN:0] rs1_res;
    logic [XLEN:0] rs2_res;
    logic          wr_block;
    logic          hazard;
    logic          fire;

    // Returns {hazard, data}. The first (youngest) matching source decides; an
    // invalid young match stalls even if an older source holds valid data.
    function automatic logic [XLEN:0] resolve(
        input logic [4:0]              a,
        input logic [CNT_W-1:0]        cnt,
        input logic [XLEN-1:0]         rf_data,
        input logic [NUM_FWD*5-1:0]    f_reg,
        input logic [NUM_FWD*XLEN-1:0] f_data,
        input logic [NUM_FWD-1:0]      f_valid
    );
        logic [XLEN:0] res;
        logic          found;
        res   = '0;
        found = 1'b0;
        if (a == 5'd0) begin
            res = '0;
        end else if (cnt == '0) begin
            res = {1'b0, rf_data};
        end else begin
            res = {1'b1, {XLEN{1'b0}}};
            for (int k = 0; k < NUM_FWD; k++) begin
                if (!found && f_reg[5*k +: 5] == a) begin
                    found = 1'b1;
                    if (f_valid[k]) begin
                        res = {1'b0, f_data[XLEN*k +: XLEN]};
                    end
                end
            end
        end
        return res;
    endfunction

    always_comb begin
        rs1_res  = resolve(rs1_i, cnt_q[rs1_i], reg_rdata1_i, fwd_reg_i, fwd_data_i, fwd_valid_i);
        rs2_res  = resolve(rs2_i, cnt_q[rs2_i], reg_rdata2_i, fwd_reg_i, fwd_data_i, fwd_valid_i);
        wr_block = wb_en_i && (rd_i != 5'd0) && (cnt_q[rd_i] == CNT_MAX)
                   && !(retire_en_i && retire_reg_i == rd_i);
        hazard   = (rs1_req_i && rs1_res[XLEN]) || (rs2_req_i && rs2_res[XLEN]) || wr_block;
    end

    assign in_ready_o = !hazard && !flush_i && (!out_valid_o || out_ready_i);
    assign fire       = in_valid_i && in_ready_o;

    // Net counter change; a retire against an empty counter holds it at zero.
    always_comb begin
        pend_next   = '0;
        cnt_next[0] = '0;
        for (int r = 1; r < 32; r++) begin
            logic [CNT_W:0] sum;
            logic [CNT_W:0] dec;
            sum = {1'b0, cnt_q[r]}
                + (CNT_W+1)'(fire && wb_en_i && rd_i == 5'(r));
            dec = (CNT_W+1)'(retire_en_i && retire_reg_i == 5'(r))
                + (CNT_W+1)'(flush_i && out_valid_o && out_rd_o == 5'(r));
            if (sum < dec) begin
                cnt_next[r] = '0;
            end else begin
                cnt_next[r] = CNT_W'(sum - dec);
            end
            pend_next[r-1] = (cnt_next[r] != '0);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
            pending_o <= '0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_next[r];
            end
            pending_o <= pend_next;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            out_valid_o <= 1'b0;
            rs1_data_o  <= '0;
            rs2_data_o  <= '0;
            out_rd_o    <= '0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (fire) begin
            out_valid_o <= 1'b1;
            rs1_data_o  <= rs1_res[XLEN-1:0];
            rs2_data_o  <= rs2_res[XLEN-1:0];
            out_rd_o    <= wb_en_i ? rd_i : 5'd0;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_issue_scoreboard_bypass.sv
// tb/tb_issue_scoreboard_bypass.sv - directed bench for issue_scoreboard_bypass
module tb_issue_scoreboard_bypass;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs1, rs2, rd;
    logic        rs1_req, rs2_req, wb_en;
    logic [31:0] rdata1, rdata2;
    logic [14:0] fwd_reg;
    logic [95:0] fwd_data;
    logic [2:0]  fwd_valid;
    logic        retire_en;
    logic [4:0]  retire_reg;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] rs1_data, rs2_data;
    logic [4:0]  out_rd;
    logic [30:0] pending;

    int n_checks = 0;
    int n_pass   = 0;

    issue_scoreboard_bypass #(.XLEN(32), .NUM_FWD(3), .CNT_W(2)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .rs1_i        (rs1),
        .rs2_i        (rs2),
        .rs1_req_i    (rs1_req),
        .rs2_req_i    (rs2_req),
        .rd_i         (rd),
        .wb_en_i      (wb_en),
        .reg_rdata1_i (rdata1),
        .reg_rdata2_i (rdata2),
        .fwd_reg_i    (fwd_reg),
        .fwd_data_i   (fwd_data),
        .fwd_valid_i  (fwd_valid),
        .retire_en_i  (retire_en),
        .retire_reg_i (retire_reg),
        .flush_i      (flush),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .rs1_data_o   (rs1_data),
        .rs2_data_o   (rs2_data),
        .out_rd_o     (out_rd),
        .pending_o    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        rs1        = '0;
        rs2        = '0;
        rd         = '0;
        rs1_req    = 1'b0;
        rs2_req    = 1'b0;
        wb_en      = 1'b0;
        rdata1     = '0;
        rdata2     = '0;
        fwd_reg    = '0;
        fwd_data   = '0;
        fwd_valid  = '0;
        retire_en  = 1'b0;
        retire_reg = '0;
        flush      = 1'b0;
        out_ready  = 1'b1;
    endtask

    // A retire must only target a register with an outstanding write.
    always @(negedge clk) begin
        if (rstn && retire_en && retire_reg != 5'd0)
            check("retire_live", 64'(pending[retire_reg - 5'd1]), 64'd1);
    end

    initial begin
        rstn = 1'b0;
        idle();
        tick();
        tick();
        check("rst_oval", 64'(out_valid), 64'd0);
        check("rst_pend", 64'(pending), 64'd0);
        check("rst_rs1", 64'(rs1_data), 64'd0);
        check("rst_rd", 64'(out_rd), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        rstn = 1'b1;

        // reset in the middle of activity
        in_valid = 1'b1; wb_en = 1'b1; rd = 5'd5;
        tick();
        tick();
        in_valid = 1'b0; wb_en = 1'b0; rd = 5'd0;
        check("a_pend", 64'(pending), 64'h10);
        check("a_oval", 64'(out_valid), 64'd1);
        check("a_rd", 64'(out_rd), 64'd5);
        rstn = 1'b0;
        #1;
        check("a_rst_oval", 64'(out_valid), 64'd0);
        check("a_rst_pend", 64'(pending), 64'd0);
        check("a_rst_rd", 64'(out_rd), 64'd0);
        tick();
        rstn = 1'b1;
        rs1 = 5'd5; rs1_req = 1'b1; rdata1 = 32'h55AA_0001; in_valid = 1'b1;
        #1;
        check("a_rd_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("a_rd_data", 64'(rs1_data), 64'h55AA_0001);
        check("a_rd_nord", 64'(out_rd), 64'd0);

        // forward not yet valid, then valid
        idle();
        in_valid = 1'b1; wb_en = 1'b1; rd = 5'd5;
        tick();
        wb_en = 1'b0; rd = 5'd0; rs1 = 5'd5; rs1_req = 1'b1;
        fwd_reg = 15'd5; fwd_valid = 3'b000;
        #1;
        check("b_stall", 64'(in_ready), 64'd0);
        tick();
        check("b_oval_clr", 64'(out_valid), 64'd0);
        fwd_valid = 3'b001; fwd_data = 96'h1234;
        #1;
        check("b_go", 64'(in_ready), 64'd1);
        tick();
        check("b_data", 64'(rs1_data), 64'h1234);
        check("b_oval", 64'(out_valid), 64'd1);
        rs1 = 5'd0; rs1_req = 1'b0; rs2 = 5'd5; rs2_req = 1'b0; fwd_valid = 3'b000;
        #1;
        check("b_noreq", 64'(in_ready), 64'd1);
        tick();
        idle();
        retire_en = 1'b1; retire_reg = 5'd5;
        tick();
        retire_en = 1'b0;
        check("b_pend_clr", 64'(pending), 64'd0);

        // priority between two forwarders of the same register
        idle();
        in_valid = 1'b1; wb_en = 1'b1; rd = 5'd7;
        tick();
        tick();
        wb_en = 1'b0; rd = 5'd0; rs2 = 5'd7; rs2_req = 1'b1;
        fwd_reg   = {5'd7, 5'd0, 5'd7};
        fwd_data  = {32'hB, 32'h0, 32'hA};
        fwd_valid = 3'b101;
        #1;
        check("c_pend", 64'(pending), 64'h40);
        check("c_ready", 64'(in_ready), 64'd1);
        tick();
        check("c_young", 64'(rs2_data), 64'hA);
        fwd_valid = 3'b100;
        #1;
        check("c_noskip", 64'(in_ready), 64'd0);
        tick();
        check("c_oval", 64'(out_valid), 64'd0);
        idle();
        retire_en = 1'b1; retire_reg = 5'd7;
        tick();
        tick();
        retire_en = 1'b0;
        check("c_pend_clr", 64'(pending), 64'd0);

        // counter saturation blocks a fourth writer unless it retires this cycle
        idle();
        in_valid = 1'b1; wb_en = 1'b1; rd = 5'd3;
        tick();
        tick();
        tick();
        check("d_pend", 64'(pending), 64'h4);
        check("d_full", 64'(in_ready), 64'd0);
        retire_en = 1'b1; retire_reg = 5'd3;
        #1;
        check("d_retire_ok", 64'(in_ready), 64'd1);
        tick();
        retire_en = 1'b0; in_valid = 1'b0;
        #1;
        check("d_still_full", 64'(in_ready), 64'd0);
        wb_en = 1'b0; rd = 5'd0;
        retire_en = 1'b1; retire_reg = 5'd3;
        tick();
        tick();
        check("d_pend_mid", 64'(pending), 64'h4);
        tick();
        retire_en = 1'b0;
        check("d_pend_clr", 64'(pending), 64'd0);

        // back-pressure holds the output entry
        idle();
        rs1 = 5'd1; rs2 = 5'd2; rs1_req = 1'b1; rs2_req = 1'b1;
        rdata1 = 32'hDEAD; rdata2 = 32'hBEEF; out_ready = 1'b0; in_valid = 1'b1;
        #1;
        check("e_ready0", 64'(in_ready), 64'd1);
        tick();
        rdata1 = 32'h1111; rdata2 = 32'h2222;
        for (int i = 0; i < 4; i++) begin
            check("e_hold_rs1", 64'(rs1_data), 64'hDEAD);
            check("e_hold_rs2", 64'(rs2_data), 64'hBEEF);
            check("e_hold_val", 64'(out_valid), 64'd1);
            check("e_hold_rdy", 64'(in_ready), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("e_release", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("e_next_rs1", 64'(rs1_data), 64'h1111);
        check("e_next_rs2", 64'(rs2_data), 64'h2222);
        tick();
        check("e_drain", 64'(out_valid), 64'd0);

        // flush kills the entry and releases its pending write
        idle();
        in_valid = 1'b1; wb_en = 1'b1; rd = 5'd9;
        tick();
        wb_en = 1'b0; rd = 5'd0; out_ready = 1'b0; flush = 1'b1;
        #1;
        check("f_rd", 64'(out_rd), 64'd9);
        check("f_pend", 64'(pending), 64'h100);
        check("f_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("f_oval", 64'(out_valid), 64'd0);
        check("f_pend_clr", 64'(pending), 64'd0);

        // x0 never forwards and is never tracked
        out_ready = 1'b1; rs1 = 5'd0; rs1_req = 1'b1;
        fwd_reg = 15'd0; fwd_data = 96'hFFFF; fwd_valid = 3'b001; rdata1 = 32'h7777;
        in_valid = 1'b1;
        #1;
        check("g_ready", 64'(in_ready), 64'd1);
        tick();
        check("g_x0", 64'(rs1_data), 64'd0);
        check("g_oval", 64'(out_valid), 64'd1);
        idle();
        in_valid = 1'b1; wb_en = 1'b1; rd = 5'd0;
        tick();
        in_valid = 1'b0; wb_en = 1'b0;
        check("g_rd0", 64'(out_rd), 64'd0);
        tick();
        check("g_pend0", 64'(pending), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
